// File: rtl/buffer_pkg.sv
//------------------------------------------------------------------------------
// buffer_pkg : shared helpers for the multicast output buffer
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package buffer_pkg;

  localparam int unsigned c_max_addr_width = 64;

  // All-ones node address, truncated by the caller to its own address width.
  function automatic logic [c_max_addr_width-1:0] discard_addr(input int unsigned width);
    logic [c_max_addr_width-1:0] v_ones;
    v_ones = '0;
    for (int i = 0; i < int'(c_max_addr_width); i++) begin
      if (i < int'(width)) v_ones[i] = 1'b1;
    end
    return v_ones;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_async_reset.sv
//------------------------------------------------------------------------------
// fifo_async_reset : registered circular FIFO, async reset, any DEPTH >= 2
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_async_reset #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int c_pw  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int c_cw  = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ack,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ack,
  output logic [c_cw-1:0]  count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_pw-1:0]  r_wr_ptr;
  logic [c_pw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  function automatic logic [c_pw-1:0] next_ptr(input logic [c_pw-1:0] p);
    return (p == c_pw'(DEPTH - 1)) ? '0 : p + c_pw'(1);
  endfunction

  assign w_full    = (r_count == c_cw'(DEPTH));
  assign w_empty   = (r_count == '0);
  // Ack is a pure function of registered state, so a same-cycle pop never frees a slot.
  assign in_ack    = !reset && !w_full;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && in_ack;
  assign w_pop     = out_ack && out_valid;
  assign out       = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      r_count <= r_count + c_cw'(w_push) - c_cw'(w_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/buffer_output_multicast.sv
//------------------------------------------------------------------------------
// buffer_output_multicast : pairs result words with CU moves, emits DTN messages
// Revision                : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module buffer_output_multicast
  import buffer_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] FROM_ADDR  = '0,
  parameter int                    DATA_DEPTH = 5,
  parameter int                    ADDR_DEPTH = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [DATA_WIDTH-1:0]           data_data,
  input  logic                            data_valid,
  output logic                            data_ack,
  input  logic [ADDR_WIDTH-1:0]           cu_move_to,
  input  logic                            cu_move_last,
  input  logic                            cu_move_valid,
  output logic                            cu_move_ack,
  output logic [ADDR_WIDTH-1:0]           dtn_from,
  output logic [ADDR_WIDTH-1:0]           dtn_to,
  output logic [DATA_WIDTH-1:0]           dtn_data,
  output logic                            dtn_valid,
  input  logic                            dtn_ack,
  output logic [$clog2(DATA_DEPTH+1)-1:0] data_count,
  output logic [$clog2(ADDR_DEPTH+1)-1:0] addr_count
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] to;
    logic                  last;
  } move_t;

  localparam logic [ADDR_WIDTH-1:0] c_discard_addr = ADDR_WIDTH'(discard_addr(ADDR_WIDTH));

  logic [DATA_WIDTH-1:0] w_data_head;
  logic                  w_data_valid;
  move_t                 w_move_in;
  move_t                 w_move_head;
  logic                  w_move_valid;
  logic                  w_head_valid;
  logic                  w_discard;
  logic                  w_step;
  logic                  w_data_pop;

  assign w_move_in = '{to: cu_move_to, last: cu_move_last};

  fifo_async_reset #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DATA_DEPTH)
  ) u_data_fifo (
    .clock     (clock),
    .reset     (reset),
    .in        (data_data),
    .in_valid  (data_valid),
    .in_ack    (data_ack),
    .out       (w_data_head),
    .out_valid (w_data_valid),
    .out_ack   (w_data_pop),
    .count     (data_count)
  );

  fifo_async_reset #(
    .WIDTH (ADDR_WIDTH + 1),
    .DEPTH (ADDR_DEPTH)
  ) u_move_fifo (
    .clock     (clock),
    .reset     (reset),
    .in        (w_move_in),
    .in_valid  (cu_move_valid),
    .in_ack    (cu_move_ack),
    .out       (w_move_head),
    .out_valid (w_move_valid),
    .out_ack   (w_step),
    .count     (addr_count)
  );

  assign w_head_valid = w_data_valid && w_move_valid;
  assign w_discard    = (w_move_head.to == c_discard_addr);
  // Discard moves advance without DTN traffic; the word retires only on its last move.
  assign w_step       = w_head_valid && (dtn_ack || w_discard);
  assign w_data_pop   = w_step && w_move_head.last;

  assign dtn_from  = FROM_ADDR;
  assign dtn_to    = w_move_head.to;
  assign dtn_data  = w_data_head;
  assign dtn_valid = w_head_valid && !w_discard;

endmodule

`default_nettype wire

// File: tb/tb_buffer_output_multicast.sv
//------------------------------------------------------------------------------
// tb_buffer_output_multicast : queue-model bench with directed vectors
// Revision                   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_buffer_output_multicast;

  localparam int DD = 5;
  localparam int AD = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_data;
  logic        data_valid;
  logic        data_ack;
  logic [7:0]  cu_move_to;
  logic        cu_move_last;
  logic        cu_move_valid;
  logic        cu_move_ack;
  logic [7:0]  dtn_from;
  logic [7:0]  dtn_to;
  logic [31:0] dtn_data;
  logic        dtn_valid;
  logic        dtn_ack;
  logic [2:0]  data_count;
  logic [3:0]  addr_count;

  buffer_output_multicast #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .FROM_ADDR  (8'h00),
    .DATA_DEPTH (DD),
    .ADDR_DEPTH (AD)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .data_data     (data_data),
    .data_valid    (data_valid),
    .data_ack      (data_ack),
    .cu_move_to    (cu_move_to),
    .cu_move_last  (cu_move_last),
    .cu_move_valid (cu_move_valid),
    .cu_move_ack   (cu_move_ack),
    .dtn_from      (dtn_from),
    .dtn_to        (dtn_to),
    .dtn_data      (dtn_data),
    .dtn_valid     (dtn_valid),
    .dtn_ack       (dtn_ack),
    .data_count    (data_count),
    .addr_count    (addr_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] to;
    logic       last;
  } mv_t;

  logic [31:0] mdq[$];
  mv_t         mmq[$];
  logic [7:0]  cap_to[$];
  logic [31:0] cap_data[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue model: one data queue, one move queue, rules applied per clock.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mdq.delete();
      mmq.delete();
    end else begin
      bit hv, disc, st, dpush, mpush;
      mv_t nm;
      hv    = (mdq.size() > 0) && (mmq.size() > 0);
      disc  = hv && (mmq[0].to == 8'hFF);
      st    = hv && (dtn_ack || disc);
      dpush = data_valid && (mdq.size() < DD);
      mpush = cu_move_valid && (mmq.size() < AD);
      if (st) begin
        if (mmq[0].last) void'(mdq.pop_front());
        void'(mmq.pop_front());
      end
      if (dpush) mdq.push_back(data_data);
      if (mpush) begin
        nm.to = cu_move_to;
        nm.last = cu_move_last;
        mmq.push_back(nm);
      end
    end
  end

  always @(posedge clock) begin
    if (!reset && dtn_valid && dtn_ack) begin
      cap_to.push_back(dtn_to);
      cap_data.push_back(dtn_data);
    end
  end

  always @(negedge clock) begin
    bit hv, ev;
    hv = (mdq.size() > 0) && (mmq.size() > 0);
    ev = hv ? (mmq[0].to != 8'hFF) : 1'b0;
    chk("data_ack", data_ack, !reset && (mdq.size() < DD));
    chk("cu_move_ack", cu_move_ack, !reset && (mmq.size() < AD));
    chk("dtn_valid", dtn_valid, ev);
    chk("data_count", data_count, mdq.size());
    chk("addr_count", addr_count, mmq.size());
    chk("dtn_from", dtn_from, 8'h00);
    if (ev) begin
      chk("dtn_to", dtn_to, mmq[0].to);
      chk("dtn_data", dtn_data, mdq[0]);
    end
  end

  // All stimulus tasks are entered and left on a falling edge.
  task automatic send_data(input logic [31:0] d);
    int n = 0;
    data_data  = d;
    data_valid = 1'b1;
    while (!data_ack && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!data_ack) chk("send_data_timeout", 0, 1);
    @(negedge clock);
    data_valid = 1'b0;
  endtask

  task automatic send_move(input logic [7:0] to, input logic last);
    int n = 0;
    cu_move_to    = to;
    cu_move_last  = last;
    cu_move_valid = 1'b1;
    while (!cu_move_ack && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!cu_move_ack) chk("send_move_timeout", 0, 1);
    @(negedge clock);
    cu_move_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((data_count != 0 || addr_count != 0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (data_count != 0 || addr_count != 0) chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic check_cap(input int idx, input logic [7:0] to, input logic [31:0] d);
    if (idx >= cap_to.size()) begin
      chk("cap_missing", cap_to.size(), idx + 1);
    end else begin
      chk("cap_to", cap_to[idx], to);
      chk("cap_data", cap_data[idx], d);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    data_data = '0; data_valid = 1'b0;
    cu_move_to = '0; cu_move_last = 1'b0; cu_move_valid = 1'b0;
    dtn_ack = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_data_ack", data_ack, 0);
    chk("rst_move_ack", cu_move_ack, 0);
    chk("rst_dtn_valid", dtn_valid, 0);
    chk("rst_data_count", data_count, 0);
    chk("rst_addr_count", addr_count, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_data_ack", data_ack, 1);

    // Unicast
    @(negedge clock);
    dtn_ack = 1'b1;
    send_data(32'hA5A5_0001);
    send_move(8'd3, 1'b1);
    wait_idle();
    repeat (2) @(negedge clock);
    chk("uni_count", cap_to.size(), 1);
    check_cap(0, 8'd3, 32'hA5A5_0001);
    chk("uni_dcount", data_count, 0);
    cap_to.delete(); cap_data.delete();

    // Multicast, held back so occupancy can be read after each step
    dtn_ack = 1'b0;
    send_data(32'h1234_5678);
    send_move(8'd2, 1'b0);
    send_move(8'd5, 1'b0);
    send_move(8'd7, 1'b1);
    chk("mc_dcount0", data_count, 1);
    chk("mc_acount0", addr_count, 3);
    dtn_ack = 1'b1;
    @(negedge clock);
    chk("mc_dcount1", data_count, 1);
    chk("mc_acount1", addr_count, 2);
    @(negedge clock);
    chk("mc_dcount2", data_count, 1);
    chk("mc_acount2", addr_count, 1);
    @(negedge clock);
    chk("mc_dcount3", data_count, 0);
    chk("mc_acount3", addr_count, 0);
    chk("mc_count", cap_to.size(), 3);
    check_cap(0, 8'd2, 32'h1234_5678);
    check_cap(1, 8'd5, 32'h1234_5678);
    check_cap(2, 8'd7, 32'h1234_5678);
    cap_to.delete(); cap_data.delete();

    // Discard: skip one destination, then retire a word silently
    send_data(32'hDEAD_0001);
    send_move(8'hFF, 1'b0);
    send_move(8'd4, 1'b1);
    wait_idle();
    send_data(32'hDEAD_0002);
    send_move(8'hFF, 1'b1);
    wait_idle();
    repeat (2) @(negedge clock);
    chk("disc_count", cap_to.size(), 1);
    check_cap(0, 8'd4, 32'hDEAD_0001);
    chk("disc_dcount", data_count, 0);
    cap_to.delete(); cap_data.delete();

    // Back-pressure, full FIFO, then streaming across pointer wrap
    dtn_ack = 1'b0;
    for (int i = 0; i < 5; i++) send_data(32'hB000_0000 + i);
    chk("full_dcount", data_count, 5);
    chk("full_data_ack", data_ack, 0);
    send_move(8'd9, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("bp_valid", dtn_valid, 1);
      chk("bp_to", dtn_to, 8'd9);
      chk("bp_data", dtn_data, 32'hB000_0000);
    end
    dtn_ack = 1'b1;
    data_data = 32'hEEEE_EEEE;
    data_valid = 1'b1;
    chk("full_pop_ack", data_ack, 0);
    @(negedge clock);
    data_valid = 1'b0;
    chk("full_pop_dcount", data_count, 4);
    for (int i = 1; i < 5; i++) send_move(8'd20 + 8'(i), 1'b1);
    for (int i = 5; i < 25; i++) begin
      send_data(32'hB000_0000 + i);
      send_move(8'd20 + 8'(i), 1'b1);
    end
    wait_idle();
    repeat (2) @(negedge clock);
    chk("wrap_count", cap_to.size(), 25);
    check_cap(0, 8'd9, 32'hB000_0000);
    for (int i = 1; i < 25; i++) check_cap(i, 8'd20 + 8'(i), 32'hB000_0000 + i);
    cap_to.delete(); cap_data.delete();

    // Async reset after the first of three destinations
    dtn_ack = 1'b0;
    send_data(32'hC0DE_0001);
    send_move(8'd1, 1'b0);
    send_move(8'd2, 1'b0);
    send_move(8'd3, 1'b1);
    dtn_ack = 1'b1;
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("ar_dtn_valid", dtn_valid, 0);
    chk("ar_dcount", data_count, 0);
    chk("ar_acount", addr_count, 0);
    chk("ar_data_ack", data_ack, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("ar_count", cap_to.size(), 1);
    check_cap(0, 8'd1, 32'hC0DE_0001);
    send_data(32'hC0DE_0002);
    send_move(8'd6, 1'b1);
    wait_idle();
    repeat (2) @(negedge clock);
    chk("ar_after_count", cap_to.size(), 2);
    check_cap(1, 8'd6, 32'hC0DE_0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
